mem_arb: RTL and testbench

Two-requester memory arbiter/sequencer for the multi-cycle RV64 core. It shares the single data-memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write). The LSU requests are the ones the control decoder raises with mem_r/mem_w. The block grants one request at a time, holds it on the memory port until accepted, and routes the single response back to its owner.

---
 rtl/core_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_arb.sv | 145 ++++++++++++++
 tb/tb_mem_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and request owner encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package core_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Which requester owns the in-flight memory transaction
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker: grants whichever requester is valid, alternating on a tie.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module mem_arb_pick
    import core_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_grant,
    output logic   grant,
    output owner_e winner
);

    // On a tie, favour the requester that did not win last time
    always_comb begin
        grant  = ifu_valid | lsu_valid;
        winner = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            winner = (last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (lsu_valid) begin
            winner = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory port between IFU (read) and LSU (read/write); one transaction at a time.
// Latency: grant cycle 0, mem_req_valid cycle 1, response routed combinationally in its arrival cycle.
// Backpressure: holds the registered request in ISSUE while mem_req_ready=0; req_ready only in IDLE.
module mem_arb
    import core_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    state_e              state_q, state_d;
    owner_e              last_grant_q, last_grant_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;

    logic   pick_grant;
    owner_e pick_winner;

    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .winner     (pick_winner)
    );

    // Next-state, request capture and combinational ready/response routing
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_grant) begin
                    last_grant_d = pick_winner;
                    owner_d      = pick_winner;
                    state_d      = ST_ISSUE;
                    if (pick_winner == OWN_LSU) begin
                        lsu_req_ready = 1'b1;
                        addr_d        = lsu_addr;
                        wen_d         = lsu_wen;
                        wdata_d       = lsu_wdata;
                        wmask_d       = lsu_wmask;
                    end else begin
                        // Fetches are always plain reads
                        ifu_req_ready = 1'b1;
                        addr_d        = ifu_addr;
                        wen_d         = 1'b0;
                        wdata_d       = '0;
                        wmask_d       = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    ifu_resp_valid = (owner_q == OWN_IFU);
                    lsu_resp_valid = (owner_q == OWN_LSU);
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A cycle with reset asserted neither accepts nor completes anything
        if (rst) begin
            ifu_req_ready  = 1'b0;
            lsu_req_ready  = 1'b0;
            ifu_resp_valid = 1'b0;
            lsu_resp_valid = 1'b0;
        end
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWN_IFU;
            owner_q      <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign resp_rdata    = mem_rdata;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: reset, single fetch, tie alternation, stalled store, reset mid-op, spurious responses.
// Latency: inputs driven 1 time unit after posedge, outputs checked before the next posedge.
// Backpressure: memory ready and responses are driven directly by each scenario.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_resp_valid;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [63:0] resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        busy;

    int n_cmp;
    int n_bad;

    mem_arb #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        // requester valid during reset must not be accepted
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        mem_resp_valid = 1'b1;
        #3;
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_handshakes got=%b exp=0000",
                     {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
        end
        n_cmp++;
        if ({mem_req_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_busy got=%b exp=00", {mem_req_valid, busy});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
            n_bad++;
            $display("FAIL reset_fields addr=%h wdata=%h wmask=%h wen=%b exp all 0",
                     mem_addr, mem_wdata, mem_wmask, mem_wen);
        end
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_ifu_only();
        // cycle 0: grant
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        mem_req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL ifu_c0 ready_ifu/ready_lsu/mem_vld got=%b exp=100",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 64'h1234;
        #3;
        // cycle 1: request on memory port
        n_cmp++;
        if ({mem_req_valid, busy, ifu_req_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL ifu_c1 mem_vld/busy/ready got=%b exp=110",
                     {mem_req_valid, busy, ifu_req_ready});
        end
        n_cmp++;
        if ({mem_addr, mem_wen, mem_wmask} !== {64'h8000_0000, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL ifu_c1_fields addr=%h wen=%b wmask=%h exp addr=80000000 wen=0 wmask=00",
                     mem_addr, mem_wen, mem_wmask);
        end
        n_cmp++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL ifu_c1_resp got=%b exp=00", {ifu_resp_valid, lsu_resp_valid});
        end
        tick();
        // cycle 2: response
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0000_0013;
        #3;
        n_cmp++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b100 || resp_rdata !== 64'h13) begin
            n_bad++;
            $display("FAIL ifu_c2_resp ifu/lsu/memvld=%b rdata=%h exp=100 rdata=13",
                     {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, resp_rdata);
        end
        tick();
        mem_resp_valid = 1'b0;
        #3;
        n_cmp++;
        if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL ifu_c3_idle busy/ifu/lsu got=%b exp=000",
                     {busy, ifu_resp_valid, lsu_resp_valid});
        end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic exp_lsu [4];
        exp_lsu[0] = 1'b1;
        exp_lsu[1] = 1'b0;
        exp_lsu[2] = 1'b1;
        exp_lsu[3] = 1'b0;
        apply_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'hA000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'hB000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'h55;
        lsu_wmask     = 8'hFF;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            n_cmp++;
            if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu[i], ~exp_lsu[i]}) begin
                n_bad++;
                $display("FAIL rr_grant%0d lsu/ifu ready got=%b exp=%b",
                         i, {lsu_req_ready, ifu_req_ready}, {exp_lsu[i], ~exp_lsu[i]});
            end
            tick();
            #3;
            n_cmp++;
            if ({mem_req_valid, mem_wen} !== {1'b1, exp_lsu[i]} ||
                mem_addr !== (exp_lsu[i] ? 64'hB000 : 64'hA000)) begin
                n_bad++;
                $display("FAIL rr_issue%0d vld/wen=%b addr=%h exp wen=%b",
                         i, {mem_req_valid, mem_wen}, mem_addr, exp_lsu[i]);
            end
            tick();
            mem_resp_valid = 1'b1;
            #3;
            n_cmp++;
            if ({lsu_resp_valid, ifu_resp_valid} !== {exp_lsu[i], ~exp_lsu[i]}) begin
                n_bad++;
                $display("FAIL rr_resp%0d lsu/ifu resp got=%b exp=%b",
                         i, {lsu_resp_valid, ifu_resp_valid}, {exp_lsu[i], ~exp_lsu[i]});
            end
            tick();
            mem_resp_valid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_store_stall();
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        mem_req_ready = 1'b0;
        #3;
        n_cmp++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL st_grant lsu/ifu ready got=%b exp=10", {lsu_req_ready, ifu_req_ready});
        end
        tick();
        // new payload on the LSU side must not leak into the held request
        lsu_req_valid = 1'b0;
        lsu_addr      = 64'h9999;
        lsu_wen       = 1'b0;
        lsu_wdata     = 64'h1;
        lsu_wmask     = 8'hF0;
        for (int c = 0; c < 5; c++) begin
            #3;
            n_cmp++;
            if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !==
                {1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F} || lsu_req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL st_stall%0d vld=%b wen=%b addr=%h wdata=%h wmask=%h rdy=%b exp 1 1 80001000 deadbeef 0f 0",
                         c, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, lsu_req_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #3;
        n_cmp++;
        if ({lsu_resp_valid, ifu_resp_valid, mem_req_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL st_ack lsu/ifu/memvld got=%b exp=100",
                     {lsu_resp_valid, ifu_resp_valid, mem_req_valid});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_op();
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0040;
        mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        // now in WAIT
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({busy, ifu_resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL rmo_wait busy/resp got=%b exp=10", {busy, ifu_resp_valid});
        end
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBAD;
        #3;
        n_cmp++;
        if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL rmo_drop ifu/lsu/busy got=%b exp=000",
                     {ifu_resp_valid, lsu_resp_valid, busy});
        end
        tick();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 64'h8000_0080;
        #3;
        n_cmp++;
        if (ifu_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rmo_regrant ready got=%b exp=1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        #3;
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0080) begin
            n_bad++;
            $display("FAIL rmo_issue vld=%b addr=%h exp 1 80000080", mem_req_valid, mem_addr);
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h77;
        #3;
        n_cmp++;
        if (ifu_resp_valid !== 1'b1 || resp_rdata !== 64'h77) begin
            n_bad++;
            $display("FAIL rmo_resp resp=%b rdata=%h exp 1 77", ifu_resp_valid, resp_rdata);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious();
        // in IDLE
        mem_resp_valid = 1'b1;
        #3;
        n_cmp++;
        if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL sp_idle ifu/lsu/busy got=%b exp=000",
                     {ifu_resp_valid, lsu_resp_valid, busy});
        end
        tick();
        mem_resp_valid = 1'b0;
        #3;
        n_cmp++;
        if ({busy, mem_req_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL sp_idle_after busy/memvld got=%b exp=00", {busy, mem_req_valid});
        end
        // in ISSUE, memory stalled
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'hC0;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b0;
        tick();
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        #3;
        n_cmp++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b001) begin
            n_bad++;
            $display("FAIL sp_issue ifu/lsu/memvld got=%b exp=001",
                     {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
        end
        tick();
        mem_resp_valid = 1'b0;
        #3;
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 64'hC0) begin
            n_bad++;
            $display("FAIL sp_issue_hold vld=%b addr=%h exp 1 c0", mem_req_valid, mem_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #3;
        n_cmp++;
        if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL sp_final lsu/ifu got=%b exp=10", {lsu_resp_valid, ifu_resp_valid});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_ifu_only();
        test_round_robin();
        test_store_stall();
        test_reset_mid_op();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
